// File: rtl/memory_map_pkg.sv
// Shared definitions for the Hack data-memory map: address regions, base addresses
// and the VRAM arbiter state encoding.
package memory_map_pkg;

    // Decoded target of a CPU data access.
    typedef enum logic [1:0] {
        RegionRam,
        RegionVram,
        RegionKbd,
        RegionNone
    } region_e;

    localparam logic [15:0] RAM_BASE  = 16'h0000;
    localparam logic [15:0] VRAM_BASE = 16'h4000;
    localparam logic [15:0] KBD_ADDR  = 16'h6000;

    // Owner of the single VRAM port.
    typedef enum logic [1:0] {
        StCpu,
        StVidAddr,
        StVidData
    } arb_state_e;

endpackage

// File: rtl/memory_map_vram_arbiter.sv
// Arbitrates the single VRAM port between the CPU and the video scanout reader.
// Video wins when a request is pending and the CPU guard window has expired; after
// every video read the CPU owns VRAM for at least MIN_CPU_CYCLES cycles.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   cpu_addr_i      CPU VRAM word address
//   cpu_wdata_i     CPU write data
//   cpu_we_i        CPU write strobe already qualified by the VRAM region
//   cpu_busy_o      registered: high while video owns VRAM
//   vid_req_i       video read request, accepted when vid_ready_o is high
//   vid_addr_i      video VRAM word address
//   vid_ready_o     no video request pending or in flight
//   vid_rdata_o     video read data
//   vid_valid_o     one-cycle pulse qualifying vid_rdata_o
//   vram_*          VRAM port (1-cycle read latency)
module memory_map_vram_arbiter
    import memory_map_pkg::*;
#(
    parameter int unsigned MIN_CPU_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] cpu_addr_i,
    input  logic [15:0] cpu_wdata_i,
    input  logic        cpu_we_i,
    output logic        cpu_busy_o,
    input  logic        vid_req_i,
    input  logic [12:0] vid_addr_i,
    output logic        vid_ready_o,
    output logic [15:0] vid_rdata_o,
    output logic        vid_valid_o,
    output logic [12:0] vram_addr_o,
    output logic [15:0] vram_wdata_o,
    output logic        vram_we_o,
    input  logic [15:0] vram_rdata_i
);

    localparam int unsigned GuardW = (MIN_CPU_CYCLES > 0) ? $clog2(MIN_CPU_CYCLES + 1) : 1;

    arb_state_e        state_q, state_d;
    logic [GuardW-1:0] guard_q, guard_d;
    logic              pend_q, pend_d;
    logic [12:0]       pend_addr_q, pend_addr_d;
    logic              busy_q;
    logic [15:0]       vid_rdata_q, vid_rdata_d;
    logic              vid_valid_q, vid_valid_d;

    always_comb begin
        state_d     = state_q;
        guard_d     = guard_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        vid_rdata_d = vid_rdata_q;
        vid_valid_d = 1'b0;
        // CPU address drives VRAM except in the single video address cycle, so the
        // CPU read is already re-issued during StVidData and its data is ready the
        // first cycle busy is low.
        vram_addr_o = cpu_addr_i;
        vram_we_o   = 1'b0;

        if (vid_req_i && !pend_q) begin
            pend_d      = 1'b1;
            pend_addr_d = vid_addr_i;
        end

        case (state_q)
            StCpu: begin
                vram_we_o = cpu_we_i;
                if (guard_q != '0) begin
                    guard_d = guard_q - 1'b1;
                end
                if (pend_q && (guard_q == '0)) begin
                    state_d = StVidAddr;
                end
            end
            StVidAddr: begin
                vram_addr_o = pend_addr_q;
                state_d     = StVidData;
            end
            StVidData: begin
                vid_rdata_d = vram_rdata_i;
                vid_valid_d = 1'b1;
                guard_d     = GuardW'(MIN_CPU_CYCLES);
                pend_d      = 1'b0;
                state_d     = StCpu;
            end
            default: state_d = StCpu;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StCpu;
            guard_q     <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            busy_q      <= 1'b0;
            vid_rdata_q <= '0;
            vid_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_q     <= guard_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            // Registered decode of the next state, so busy tracks the video states exactly.
            busy_q      <= (state_d != StCpu);
            vid_rdata_q <= vid_rdata_d;
            vid_valid_q <= vid_valid_d;
        end
    end

    assign cpu_busy_o   = busy_q;
    assign vid_ready_o  = !pend_q;
    assign vid_rdata_o  = vid_rdata_q;
    assign vid_valid_o  = vid_valid_q;
    assign vram_wdata_o = cpu_wdata_i;

endmodule

// File: rtl/memory_map.sv
// Data-memory side of the Hack CPU. Decodes the 15-bit data address space into RAM,
// screen VRAM and the keyboard register, muxes read data back to the CPU and shares
// the VRAM port with the video scanout reader.
//
// Ports:
//   clk, reset                      system clock, synchronous active-high reset
//   cpu_address/wdata/load          CPU data access (address bit 15 ignored)
//   cpu_rdata                       read data, valid one cycle after a stable address
//   cpu_busy                        high while video owns VRAM; VRAM writes are dropped
//   vid_req/addr/ready/rdata/valid  video read channel
//   ram_*                           RAM port (1-cycle read latency)
//   vram_*                          VRAM port (1-cycle read latency)
//   kbd_code                        current key code
module memory_map #(
    parameter int unsigned MIN_CPU_CYCLES = 3,
    parameter logic [15:0] KBD_ADDR       = 16'h6000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_load,
    output logic [15:0] cpu_rdata,
    output logic        cpu_busy,
    input  logic        vid_req,
    input  logic [12:0] vid_addr,
    output logic        vid_ready,
    output logic [15:0] vid_rdata,
    output logic        vid_valid,
    output logic [13:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic [15:0] ram_rdata,
    output logic [12:0] vram_addr,
    output logic [15:0] vram_wdata,
    output logic        vram_we,
    input  logic [15:0] vram_rdata,
    input  logic [15:0] kbd_code
);
    import memory_map_pkg::*;

    region_e     region;
    region_e     sel_q;
    logic [15:0] kbd_q;
    logic        vram_wr_req;
    logic        unused_addr_msb;

    assign unused_addr_msb = cpu_address[15];

    always_comb begin
        region = RegionNone;
        if (!cpu_address[14]) begin
            region = RegionRam;
        end else if (!cpu_address[13]) begin
            region = RegionVram;
        end else if (cpu_address[14:0] == KBD_ADDR[14:0]) begin
            region = RegionKbd;
        end
    end

    assign ram_addr    = cpu_address[13:0];
    assign ram_wdata   = cpu_wdata;
    // RAM is private to the CPU, so its writes never wait on the arbiter.
    assign ram_we      = cpu_load && (region == RegionRam);
    assign vram_wr_req = cpu_load && (region == RegionVram);

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= RegionNone;
            kbd_q <= '0;
        end else begin
            sel_q <= region;
            kbd_q <= kbd_code;
        end
    end

    // Region is registered alongside the 1-cycle memory latency to steer returning data.
    always_comb begin
        cpu_rdata = 16'h0000;
        case (sel_q)
            RegionRam:  cpu_rdata = ram_rdata;
            RegionVram: cpu_rdata = vram_rdata;
            RegionKbd:  cpu_rdata = kbd_q;
            default:    cpu_rdata = 16'h0000;
        endcase
    end

    memory_map_vram_arbiter #(
        .MIN_CPU_CYCLES(MIN_CPU_CYCLES)
    ) u_vram_arbiter (
        .clk         (clk),
        .reset       (reset),
        .cpu_addr_i  (cpu_address[12:0]),
        .cpu_wdata_i (cpu_wdata),
        .cpu_we_i    (vram_wr_req),
        .cpu_busy_o  (cpu_busy),
        .vid_req_i   (vid_req),
        .vid_addr_i  (vid_addr),
        .vid_ready_o (vid_ready),
        .vid_rdata_o (vid_rdata),
        .vid_valid_o (vid_valid),
        .vram_addr_o (vram_addr),
        .vram_wdata_o(vram_wdata),
        .vram_we_o   (vram_we),
        .vram_rdata_i(vram_rdata)
    );

endmodule

// File: tb/tb_memory_map.sv
// Randomized scoreboard bench for memory_map: a reference model of the address map
// (plain arrays indexed by address range) produces expected read data, stimulus pushes
// expectations into queues and negedge monitors pop and compare them.
module tb_memory_map;

    localparam int unsigned MinCpu = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_address, cpu_wdata, cpu_rdata;
    logic        cpu_load, cpu_busy;
    logic        vid_req, vid_ready, vid_valid;
    logic [12:0] vid_addr;
    logic [15:0] vid_rdata;
    logic [13:0] ram_addr;
    logic [15:0] ram_wdata, ram_rdata;
    logic        ram_we;
    logic [12:0] vram_addr;
    logic [15:0] vram_wdata, vram_rdata;
    logic        vram_we;
    logic [15:0] kbd_code;

    always #5 clk = ~clk;

    memory_map #(
        .MIN_CPU_CYCLES(MinCpu),
        .KBD_ADDR      (16'h6000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_address(cpu_address),
        .cpu_wdata  (cpu_wdata),
        .cpu_load   (cpu_load),
        .cpu_rdata  (cpu_rdata),
        .cpu_busy   (cpu_busy),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ready  (vid_ready),
        .vid_rdata  (vid_rdata),
        .vid_valid  (vid_valid),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we),
        .vram_rdata (vram_rdata),
        .kbd_code   (kbd_code)
    );

    // Synchronous memories with 1-cycle read latency, written only by the DUT.
    logic [15:0] ram_mem  [16384];
    logic [15:0] vram_mem [8192];
    int unsigned vram_we_cnt = 0;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
        if (vram_we) vram_mem[vram_addr] <= vram_wdata;
        vram_rdata <= vram_mem[vram_addr];
        if (vram_we) vram_we_cnt <= vram_we_cnt + 1;
    end

    // Reference model of memory contents as the CPU expects to see them.
    logic [15:0] ram_model  [16384];
    logic [15:0] vram_model [8192];

    logic [15:0] vid_q[$];
    logic [15:0] cpu_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // 0 = RAM, 1 = VRAM, 2 = keyboard, 3 = unmapped
    function automatic int region_of(input logic [15:0] a);
        int unsigned off;
        off = a[14:0];
        if (off < 32'h4000) return 0;
        if (off < 32'h6000) return 1;
        if (off == 32'h6000) return 2;
        return 3;
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a);
        int unsigned off;
        off = a[14:0];
        case (region_of(a))
            0:       return ram_model[off];
            1:       return vram_model[off - 32'h4000];
            2:       return kbd_code;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // A video request is accepted at the next edge when ready; expect the data held then.
    always @(negedge clk) begin
        if (!reset && vid_req && vid_ready) vid_q.push_back(vram_model[vid_addr]);
    end

    always @(negedge clk) begin
        if (vid_valid) begin
            if (vid_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL vid_valid_unexpected: got pulse with data %h, expected none",
                         vid_rdata);
            end else begin
                check("vid_rdata", vid_rdata, vid_q.pop_front());
            end
        end
        if (cpu_q.size() != 0) check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    end

    // Called at posedge+1; returns at posedge+1 after the write has committed.
    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        int rg;
        int unsigned off;
        int waited;
        rg = region_of(a);
        off = a[14:0];
        waited = 0;
        cpu_address = a;
        cpu_wdata = d;
        cpu_load = 1'b1;
        #1;
        while (cpu_busy && waited < 20) begin
            check("vram_we_while_busy", {15'b0, vram_we}, 16'd0);
            @(posedge clk);
            #2;
            waited++;
        end
        check("busy_released_for_write", {15'b0, cpu_busy}, 16'd0);
        check("ram_we", {15'b0, ram_we}, (rg == 0) ? 16'd1 : 16'd0);
        check("vram_we", {15'b0, vram_we}, (rg == 1) ? 16'd1 : 16'd0);
        @(posedge clk);
        #1;
        cpu_load = 1'b0;
        if (rg == 0) ram_model[off] = d;
        else if (rg == 1) vram_model[off - 32'h4000] = d;
    endtask

    task automatic cpu_read(input logic [15:0] a);
        int waited;
        waited = 0;
        cpu_address = a;
        cpu_load = 1'b0;
        @(posedge clk);
        #1;
        while (cpu_busy && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (cpu_busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL cpu_read_timeout: got busy 1, expected 0");
        end else begin
            cpu_q.push_back(model_read(a));
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt, valid_cnt, ready_low, first_busy, first_valid, run, nhigh, waited;
        int unsigned we_before;
        logic [15:0] wd;
        logic [63:0] busy_hist;

        reset = 1'b1;
        cpu_address = '0;
        cpu_wdata = '0;
        cpu_load = 1'b0;
        vid_req = 1'b0;
        vid_addr = '0;
        kbd_code = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {15'b0, cpu_busy}, 16'd0);
        check("reset_ready", {15'b0, vid_ready}, 16'd1);
        check("reset_vid_valid", {15'b0, vid_valid}, 16'd0);
        check("reset_vid_rdata", vid_rdata, 16'h0000);
        check("reset_cpu_rdata", cpu_rdata, 16'h0000);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed RAM and keyboard cases.
        cpu_write(16'h0010, 16'hBEEF);
        cpu_read(16'h0010);
        check("ram_read_busy", {15'b0, cpu_busy}, 16'd0);
        cpu_read(16'h8010);
        kbd_code = 16'h0041;
        cpu_read(16'h6000);
        cpu_write(16'h6000, 16'h1234);
        cpu_read(16'h6001);
        cpu_read(16'h7FFF);

        // Fill a working window of RAM and VRAM so later reads are defined.
        for (int i = 0; i < 64; i++) begin
            cpu_write(16'(i), 16'($urandom));
            cpu_write(16'h4000 + 16'(i), 16'($urandom));
        end

        for (int n = 0; n < 150; n++) begin
            int op;
            op = $urandom_range(0, 6);
            case (op)
                0: cpu_write(16'($urandom_range(0, 63)), 16'($urandom));
                1: cpu_write(16'h4000 + 16'($urandom_range(0, 63)), 16'($urandom));
                2: cpu_read(16'($urandom_range(0, 63)) | ($urandom_range(0, 1) ? 16'h8000 : 16'h0));
                3: cpu_read(16'h4000 + 16'($urandom_range(0, 63)));
                4: begin
                    kbd_code = 16'($urandom);
                    cpu_read(16'h6000);
                end
                5: cpu_read(16'h6001 + 16'($urandom_range(0, 16'h1FFE)));
                default: cpu_write(16'h6000 + 16'($urandom_range(0, 16'h1FFF)), 16'($urandom));
            endcase
        end

        // Single video read: busy for exactly two cycles, one valid pulse.
        cpu_write(16'h4123, 16'h5A5A);
        repeat (4) @(posedge clk);
        #1;
        check("vid_ready_idle", {15'b0, vid_ready}, 16'd1);
        vid_addr = 13'h123;
        vid_req = 1'b1;
        @(posedge clk);
        #1;
        vid_req = 1'b0;
        busy_cnt = 0;
        valid_cnt = 0;
        ready_low = 0;
        first_busy = -1;
        first_valid = -1;
        for (int c = 0; c < 10; c++) begin
            if (cpu_busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = c;
            end
            if (vid_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = c;
            end
            if (!vid_ready) ready_low++;
            @(posedge clk);
            #1;
        end
        check("vid_busy_cycles", 16'(busy_cnt), 16'd2);
        check("vid_busy_start", 16'(first_busy), 16'd1);
        check("vid_valid_pulses", 16'(valid_cnt), 16'd1);
        check("vid_valid_cycle", 16'(first_valid), 16'd3);
        check("vid_ready_low_cycles", 16'(ready_low), 16'd3);

        // CPU write held across a video access commits exactly once, after busy falls.
        vid_addr = 13'd5;
        vid_req = 1'b1;
        @(posedge clk);
        #1;
        vid_req = 1'b0;
        waited = 0;
        while (!cpu_busy && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("busy_seen_before_write", {15'b0, cpu_busy}, 16'd1);
        we_before = vram_we_cnt;
        wd = 16'($urandom);
        cpu_write(16'h4001, wd);
        check("vram_we_pulses", 16'(vram_we_cnt - we_before), 16'd1);
        cpu_read(16'h4001);

        // Continuous video requests: busy alternates 2 high / at least MinCpu low.
        vid_req = 1'b1;
        for (int c = 0; c < 64; c++) begin
            vid_addr = 13'($urandom_range(3, 63));
            busy_hist[c] = cpu_busy;
            @(posedge clk);
            #1;
        end
        run = 1;
        nhigh = 0;
        for (int c = 1; c < 64; c++) begin
            if (busy_hist[c] == busy_hist[c-1]) begin
                run++;
            end else begin
                if (c - run > 0) begin
                    if (busy_hist[c-1]) begin
                        nhigh++;
                        check("starve_high_run", 16'(run), 16'd2);
                    end else begin
                        n_tests++;
                        if (run < int'(MinCpu)) begin
                            n_fail++;
                            $display("FAIL starve_low_run: got %0d cycles, expected at least %0d",
                                     run, MinCpu);
                        end
                    end
                end
                run = 1;
            end
        end
        n_tests++;
        if (nhigh < 8) begin
            n_fail++;
            $display("FAIL starve_video_service: got %0d video accesses, expected at least 8",
                     nhigh);
        end
        vid_addr = 13'd10;
        cpu_write(16'h4002, 16'($urandom));
        for (int k = 0; k < 4; k++) cpu_read(16'h4002);
        for (int k = 0; k < 4; k++) cpu_read(16'h4000 + 16'($urandom_range(3, 63)));
        vid_req = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("vid_q_drained", 16'(vid_q.size()), 16'd0);

        // Reset during the video data cycle abandons the read.
        vid_addr = 13'd7;
        vid_req = 1'b1;
        @(posedge clk);
        #1;
        vid_req = 1'b0;
        waited = 0;
        while (!cpu_busy && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("reset_test_busy_seen", {15'b0, cpu_busy}, 16'd1);
        @(posedge clk);
        #1;
        check("reset_test_in_data_cycle", {15'b0, cpu_busy}, 16'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_vid_valid", {15'b0, vid_valid}, 16'd0);
        check("mid_reset_busy", {15'b0, cpu_busy}, 16'd0);
        vid_q.delete();
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_busy", {15'b0, cpu_busy}, 16'd0);
        check("post_reset_ready", {15'b0, vid_ready}, 16'd1);
        check("post_reset_vid_valid", {15'b0, vid_valid}, 16'd0);
        repeat (6) @(posedge clk);
        #1;
        check("cpu_q_drained", 16'(cpu_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_map.md
Name: memory_map

Overview:
- Data-memory side of the Hack CPU; consumes the CPU's mem_address/mem_wdata/mem_load and produces mem_rdata/mem_busy.
- Decodes the 15-bit Hack data address space:
  - RAM 0x0000–0x3FFF
  - screen VRAM 0x4000–0x5FFF
  - keyboard 0x6000
- Arbitrates the single VRAM port between the CPU and the video scanout reader.
- Video has priority; a guaranteed CPU window prevents starvation.

Parameters:
- MIN_CPU_CYCLES, 3, minimum consecutive cycles of CPU VRAM ownership after each video access.
- KBD_ADDR, 16'h6000, keyboard register address.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_address  in  16  data address; bit 15 ignored
- cpu_wdata  in  16  write data
- cpu_load  in  1  write strobe; may be high while cpu_busy is high
- cpu_rdata  out  16  read data
- cpu_busy  out  1  registered; high while video owns VRAM
- vid_req  in  1  video read request, sampled when vid_ready=1
- vid_addr  in  13  VRAM word address
- vid_ready  out  1  high when no video request pending/in flight
- vid_rdata  out  16  video read data
- vid_valid  out  1  one-cycle pulse, vid_rdata valid
- ram_addr  out  14  RAM address
- ram_wdata  out  16  RAM write data
- ram_we  out  1  RAM write enable
- ram_rdata  in  16  RAM read data, 1-cycle latency
- vram_addr  out  13  VRAM address
- vram_wdata  out  16  VRAM write data
- vram_we  out  1  VRAM write enable
- vram_rdata  in  16  VRAM read data, 1-cycle latency
- kbd_code  in  16  current key code

Behaviour:
- Region decode (combinational on cpu_address[14:0]):
  - RAM when [14]=0.
  - VRAM when [14:13]=2'b10.
  - KBD when address==KBD_ADDR.
  - Else NONE; reads return 0, writes dropped.
- RAM path:
  - ram_addr=cpu_address[13:0], ram_wdata=cpu_wdata.
  - ram_we = cpu_load && region==RAM; never gated by busy.
- Keyboard:
  - kbd_q <= kbd_code every cycle.
  - Writes to KBD ignored.
- Read path:
  - sel_q <= region each cycle.
  - cpu_rdata = mux(sel_q): ram_rdata / vram_rdata / kbd_q / 16'h0.
  - Fast-region read data valid 1 cycle after address is stable.
- Arbiter FSM (owner of VRAM port):
  - CPU: vram_addr=cpu_address[12:0], cpu_busy=0.
    - If pend && guard==0: → VID_ADDR.
  - VID_ADDR: vram_addr=pend_addr, vram_we=0, cpu_busy=1. → VID_DATA.
  - VID_DATA: cpu_busy=1.
    - vid_rdata<=vram_rdata; vid_valid<=1 (pulse, visible next cycle).
    - guard<=MIN_CPU_CYCLES; pend<=0. → CPU.
  - cpu_busy is a registered decode of state: high exactly in VID_ADDR and VID_DATA.
- Guard counter:
  - Decrements by 1 per cycle in CPU state while nonzero, saturating at 0.
  - Reset value 0.
- Request capture:
  - vid_ready = !pend.
  - vid_req && vid_ready → pend<=1, pend_addr<=vid_addr.
  - vid_req while pend=1 is ignored.
- VRAM write commit:
  - vram_we = cpu_load && region==VRAM && state==CPU.
  - A write in a busy=0 cycle is always committed that cycle.
  - A write while busy=1 is dropped; the CPU holds cpu_load until it sees busy=0.
- CPU VRAM read timing:
  - After busy falls, vram_addr follows CPU immediately.
  - cpu_rdata is valid from the 1st cycle after the busy-fall edge and remains valid while address is stable and owner=CPU.
  - The CPU's 2-cycle wait is sufficient.
- Simultaneous events:
  - vid_req in the same cycle guard reaches 0: pend set, VID_ADDR entered the following cycle.
  - A CPU write in the last CPU cycle before VID_ADDR commits.
- Reset values:
  - state=CPU, cpu_busy=0, pend=0, guard=0.
  - vid_valid=0, vid_rdata=0, sel_q=NONE, kbd_q=0, vid_ready=1.
- Reset mid-access: an in-flight video read is abandoned with no vid_valid; the next cycle is CPU state.

Decomposition:
- Shared package holds:
  - region enum {RAM, VRAM, KBD, NONE}
  - base constants RAM_BASE=0x0000, VRAM_BASE=0x4000, KBD_ADDR=0x6000
  - arbiter state encoding
- One natural sub-module: vram_arbiter (FSM, guard counter, pend capture, busy, VRAM port muxing).
- Decode and read mux stay in memory_map.

Test Plan:
- RAM write/read: cpu_load=1, addr=0x0010, wdata=0xBEEF → ram_we pulse; then read 0x0010 → cpu_rdata=0xBEEF one cycle later; cpu_busy stays 0.
- Keyboard: kbd_code=0x0041, read 0x6000 → cpu_rdata=0x0041 after 2 cycles; write 0x6000 → no ram_we/vram_we; read 0x6001 → 0x0000.
- Video read: preload VRAM[0x0123]=0x5A5A, vid_req addr 0x0123 → cpu_busy high exactly 2 cycles, vid_valid single pulse with vid_rdata=0x5A5A, vid_ready low until completion.
- Write during busy: cpu_load to 0x4001 held across video access → vram_we low while busy=1, single vram_we pulse in first busy=0 cycle, VRAM[1] updated once.
- Starvation guard: vid_req every cycle → busy pattern 2 high / ≥3 low repeating; CPU VRAM read of 0x4002 returns correct data within the low window.
- Reset mid-access: assert reset during VID_DATA → no vid_valid, cpu_busy=0 and vid_ready=1 the cycle after reset deasserts.
